rggen_bus_arbiter: RTL and testbench

- Shares one rggen_bus_if register-bus port between TOTAL_HOSTS bus hosts (CPU bridge, debug port, DMA config engine).
- Sits between the host-side protocol bridges and the bus splitter. Its single master port connects directly to the splitter's slave port.
- Round-robin arbitration. One transaction in flight at a time. The grant is held from request until `done`.
- An optional watchdog terminates hung transactions.

---
 rtl/rggen_bus_arbiter_if.sv | 37 +++
 rtl/rggen_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_bus_pkg / rggen_bus_if                                               |
// | Register-bus response codes and the host/splitter bus interface.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package rggen_bus_pkg;
    localparam logic [1:0] RGGEN_OKAY        = 2'b00;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
endpackage

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                      request;
    logic [ADDRESS_WIDTH-1:0]  address;
    logic                      direction;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strobe;
    logic                      done;
    logic                      read_done;
    logic                      write_done;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [1:0]                status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_done, write_done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_done, write_done, read_data, status
    );
endinterface
`default_nettype wire

// File: rtl/rggen_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rggen_bus_arbiter                                                          |
// | Round-robin sharing of one register-bus port among TOTAL_HOSTS hosts.      |
// | Optional watchdog: define RGGEN_BUS_ARBITER_TIMEOUT_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rggen_bus_arbiter
    import rggen_bus_pkg::*;
#(
    parameter int TOTAL_HOSTS    = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rggen_bus_if.slave             host_if [TOTAL_HOSTS],
    rggen_bus_if.master            bus_if,
    output logic [TOTAL_HOSTS-1:0] grant
);
    localparam int c_LAST_WIDTH   = (TOTAL_HOSTS > 1) ? $clog2(TOTAL_HOSTS) : 1;
    localparam int c_STROBE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    if (TOTAL_HOSTS < 1 || TOTAL_HOSTS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rggen_bus_arbiter: illegal parameter value");
    end

    state_t                    r_state;
    logic [TOTAL_HOSTS-1:0]    r_grant;
    logic [c_LAST_WIDTH-1:0]   r_last;

    logic [TOTAL_HOSTS-1:0]    w_host_request;
    logic [TOTAL_HOSTS-1:0]    w_host_direction;
    logic [ADDRESS_WIDTH-1:0]  w_host_address      [TOTAL_HOSTS];
    logic [DATA_WIDTH-1:0]     w_host_write_data   [TOTAL_HOSTS];
    logic [c_STROBE_WIDTH-1:0] w_host_write_strobe [TOTAL_HOSTS];

    logic [ADDRESS_WIDTH-1:0]  w_sel_address;
    logic                      w_sel_direction;
    logic [DATA_WIDTH-1:0]     w_sel_write_data;
    logic [c_STROBE_WIDTH-1:0] w_sel_write_strobe;

    logic                      w_found;
    logic [TOTAL_HOSTS-1:0]    w_next_grant;
    logic [c_LAST_WIDTH-1:0]   w_next_index;
    logic                      w_timeout;

    for (genvar g = 0; g < TOTAL_HOSTS; g++) begin : g_host
        assign w_host_request[g]      = host_if[g].request;
        assign w_host_direction[g]    = host_if[g].direction;
        assign w_host_address[g]      = host_if[g].address;
        assign w_host_write_data[g]   = host_if[g].write_data;
        assign w_host_write_strobe[g] = host_if[g].write_strobe;

        // Only the owner ever sees a response; a watchdog expiry is reported as a slave error.
        assign host_if[g].done       = r_grant[g] & (bus_if.done | w_timeout);
        assign host_if[g].read_done  = r_grant[g] & (bus_if.read_done  | (w_timeout & ~w_host_direction[g]));
        assign host_if[g].write_done = r_grant[g] & (bus_if.write_done | (w_timeout &  w_host_direction[g]));
        assign host_if[g].read_data  = (r_grant[g] & bus_if.done) ? bus_if.read_data : '0;
        assign host_if[g].status     = !r_grant[g] ? RGGEN_OKAY        :
                                       bus_if.done ? bus_if.status     :
                                       w_timeout   ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    end

    // Scan hosts above the last winner first, then wrap around to the rest.
    always_comb begin
        w_found      = 1'b0;
        w_next_grant = '0;
        w_next_index = '0;
        for (int i = 0; i < TOTAL_HOSTS; i++) begin
            if (!w_found && w_host_request[i] && (i > int'(r_last))) begin
                w_found         = 1'b1;
                w_next_grant[i] = 1'b1;
                w_next_index    = c_LAST_WIDTH'(i);
            end
        end
        for (int i = 0; i < TOTAL_HOSTS; i++) begin
            if (!w_found && w_host_request[i] && (i <= int'(r_last))) begin
                w_found         = 1'b1;
                w_next_grant[i] = 1'b1;
                w_next_index    = c_LAST_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_sel_address      = '0;
        w_sel_direction    = 1'b0;
        w_sel_write_data   = '0;
        w_sel_write_strobe = '0;
        for (int i = 0; i < TOTAL_HOSTS; i++) begin
            if (r_grant[i]) begin
                w_sel_address      = w_sel_address      | w_host_address[i];
                w_sel_direction    = w_sel_direction    | w_host_direction[i];
                w_sel_write_data   = w_sel_write_data   | w_host_write_data[i];
                w_sel_write_strobe = w_sel_write_strobe | w_host_write_strobe[i];
            end
        end
    end

    // Request follows ownership, so a host that drops request early still completes.
    assign bus_if.request      = (r_state == BUSY) & ~w_timeout;
    assign bus_if.address      = w_sel_address;
    assign bus_if.direction    = w_sel_direction;
    assign bus_if.write_data   = w_sel_write_data;
    assign bus_if.write_strobe = w_sel_write_strobe;
    assign grant               = r_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= c_LAST_WIDTH'(TOTAL_HOSTS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= BUSY;
                        r_grant <= w_next_grant;
                        r_last  <= w_next_index;
                    end
                end
                BUSY: begin
                    if (bus_if.done || w_timeout) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int c_COUNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_COUNT_WIDTH-1:0] r_count;

    // A real done in the expiry cycle takes precedence over the watchdog.
    assign w_timeout = (r_state == BUSY) && !bus_if.done &&
                       (r_count == c_COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state == IDLE) begin
            r_count <= '0;
        end else if (!bus_if.done) begin
            r_count <= r_count + c_COUNT_WIDTH'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rggen_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rggen_bus_arbiter                                                       |
// | Directed and random bench for rggen_bus_arbiter with a reference model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rggen_bus_arbiter;
    import rggen_bus_pkg::*;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          h_req   [N];
    logic [AW-1:0] h_addr  [N];
    logic          h_dir   [N];
    logic [DW-1:0] h_wdata [N];
    logic [SW-1:0] h_strb  [N];
    logic          o_done  [N];
    logic          o_rdone [N];
    logic          o_wdone [N];
    logic [DW-1:0] o_rdata [N];
    logic [1:0]    o_status[N];

    logic          sp_done, sp_rdone, sp_wdone;
    logic [DW-1:0] sp_rdata;
    logic [1:0]    sp_status;
    logic [N-1:0]  grant;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) host_if [N] ();
    rggen_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    for (genvar g = 0; g < N; g++) begin : g_host
        assign host_if[g].request      = h_req[g];
        assign host_if[g].address      = h_addr[g];
        assign host_if[g].direction    = h_dir[g];
        assign host_if[g].write_data   = h_wdata[g];
        assign host_if[g].write_strobe = h_strb[g];
        assign o_done[g]   = host_if[g].done;
        assign o_rdone[g]  = host_if[g].read_done;
        assign o_wdone[g]  = host_if[g].write_done;
        assign o_rdata[g]  = host_if[g].read_data;
        assign o_status[g] = host_if[g].status;
    end

    assign bus_if.done       = sp_done;
    assign bus_if.read_done  = sp_rdone;
    assign bus_if.write_done = sp_wdone;
    assign bus_if.read_data  = sp_rdata;
    assign bus_if.status     = sp_status;

    rggen_bus_arbiter #(
        .TOTAL_HOSTS    (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host_if (host_if),
        .bus_if  (bus_if),
        .grant   (grant)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when idle), last winner, busy-cycle count.
    int m_owner, m_last, m_count;

    // Splitter behaviour and observation capture.
    bit            sp_auto, sp_rand;
    int            sp_lat, sp_cnt;
    logic [DW-1:0] sp_next_rdata;
    logic [1:0]    sp_next_status;
    bit            seen_done [N];
    logic [DW-1:0] cap_rdata [N];
    logic [1:0]    cap_status[N];
    bit            cap_rd    [N];
    bit            cap_wr    [N];
    int            done_cnt  [N];
    int            wr_cnt    [N];
    bit            obs_bus_req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_to();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        return (m_owner >= 0) && (m_count == TO - 1) && !sp_done;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update();
        bit to;
        to = m_to();
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_count = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (m_owner < 0 && h_req[j]) begin
                    m_owner = j;
                    m_last  = j;
                    m_count = 0;
                end
            end
        end else if (sp_done || to) begin
            m_owner = -1;
        end else begin
            m_count++;
        end
    endtask

    task automatic check_all();
        bit            to, busy;
        int            own;
        logic [N-1:0]  eg;
        to   = m_to();
        busy = (m_owner >= 0);
        own  = busy ? m_owner : 0;
        eg   = '0;
        if (busy) eg[own] = 1'b1;
        check("grant", grant, eg);
        check("bus_request", bus_if.request, busy && !to);
        check("bus_address", bus_if.address, busy ? h_addr[own] : '0);
        check("bus_direction", bus_if.direction, busy ? h_dir[own] : 1'b0);
        check("bus_write_data", bus_if.write_data, busy ? h_wdata[own] : '0);
        check("bus_write_strobe", bus_if.write_strobe, busy ? h_strb[own] : '0);
        for (int h = 0; h < N; h++) begin
            bit sel;
            sel = busy && (h == own);
            check($sformatf("h%0d_done", h), o_done[h], sel && (sp_done || to));
            check($sformatf("h%0d_read_done", h), o_rdone[h],
                  sel && (sp_done ? sp_rdone : (to && !h_dir[h])));
            check($sformatf("h%0d_write_done", h), o_wdone[h],
                  sel && (sp_done ? sp_wdone : (to && h_dir[h])));
            check($sformatf("h%0d_read_data", h), o_rdata[h], (sel && sp_done) ? sp_rdata : '0);
            check($sformatf("h%0d_status", h), o_status[h],
                  !sel ? RGGEN_OKAY : sp_done ? sp_status : to ? RGGEN_SLAVE_ERROR : RGGEN_OKAY);
        end
    endtask

    task automatic splitter_drive();
        if (bus_if.request) begin
            if (sp_cnt >= sp_lat) begin
                sp_done   = 1'b1;
                sp_rdone  = !bus_if.direction;
                sp_wdone  = bus_if.direction;
                sp_rdata  = bus_if.direction ? '0 : sp_next_rdata;
                sp_status = sp_next_status;
                sp_cnt    = 0;
                if (sp_rand) begin
                    sp_lat         = $urandom_range(0, 3);
                    sp_next_rdata  = DW'($urandom);
                    sp_next_status = ($urandom_range(0, 1) != 0) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
                end
            end else begin
                sp_cnt++;
            end
        end
    endtask

    task automatic cycle();
        #1;
        if (sp_auto) splitter_drive();
        #1;
        check_all();
        for (int h = 0; h < N; h++) begin
            seen_done[h] = o_done[h];
            if (o_done[h]) begin
                cap_rdata[h]  = o_rdata[h];
                cap_status[h] = o_status[h];
                cap_rd[h]     = o_rdone[h];
                cap_wr[h]     = o_wdone[h];
                done_cnt[h]++;
                if (o_wdone[h]) wr_cnt[h]++;
            end
        end
        obs_bus_req = bus_if.request;
        @(posedge clk);
        model_update();
        if (!rst_n) sp_cnt = 0;
        @(negedge clk);
        if (sp_auto) begin
            sp_done   = 1'b0;
            sp_rdone  = 1'b0;
            sp_wdone  = 1'b0;
            sp_rdata  = '0;
            sp_status = RGGEN_OKAY;
        end
    endtask

    task automatic wait_done(input int h, input int max, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!seen_done[h] && n < max);
        check($sformatf("wait_done_h%0d", h), seen_done[h], 1'b1);
    endtask

    task automatic host_cmd(input int h, input bit dir, input logic [AW-1:0] a, input logic [DW-1:0] d);
        h_req[h]   = 1'b1;
        h_dir[h]   = dir;
        h_addr[h]  = a;
        h_wdata[h] = d;
        h_strb[h]  = dir ? 4'hF : 4'h0;
    endtask

    initial begin
        int n, d0, lows, idx;
        int ord [4];
        bit started;

        for (int h = 0; h < N; h++) begin
            h_req[h] = 1'b0; h_addr[h] = '0; h_dir[h] = 1'b0; h_wdata[h] = '0; h_strb[h] = '0;
            seen_done[h] = 1'b0; done_cnt[h] = 0; wr_cnt[h] = 0;
            cap_rdata[h] = '0; cap_status[h] = '0; cap_rd[h] = 1'b0; cap_wr[h] = 1'b0;
        end
        sp_done = 1'b0; sp_rdone = 1'b0; sp_wdone = 1'b0; sp_rdata = '0; sp_status = RGGEN_OKAY;
        sp_auto = 1'b1; sp_rand = 1'b0; sp_lat = 2; sp_cnt = 0;
        sp_next_rdata = '0; sp_next_status = RGGEN_OKAY; obs_bus_req = 1'b0;
        m_owner = -1; m_last = N - 1; m_count = 0;

        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();
        check("reset_grant", grant, 2'b00);
        check("reset_bus_request", bus_if.request, 1'b0);
        rst_n = 1'b1;

        // Single read by host 0
        host_cmd(0, 1'b0, 16'h0010, '0);
        sp_lat = 2; sp_next_rdata = 32'hA5A5_0001; sp_next_status = RGGEN_OKAY;
        wait_done(0, 12, n);
        check("read_latency", n, 4);
        check("read_data", cap_rdata[0], 32'hA5A5_0001);
        check("read_status", cap_status[0], RGGEN_OKAY);
        check("read_done_flag", cap_rd[0], 1'b1);
        check("h1_no_done", done_cnt[1], 0);
        h_req[0] = 1'b0;
        cycle();

        // Simultaneous held requests right after reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        host_cmd(0, 1'b0, 16'h0100, '0);
        host_cmd(1, 1'b1, 16'h0200, 32'hCAFE_0001);
        sp_lat = 1; sp_next_rdata = 32'h0000_1111;
        idx = 0;
        for (int i = 0; i < 4; i++) ord[i] = -1;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            cycle();
            for (int h = 0; h < N; h++) begin
                if (seen_done[h] && idx < 4) begin
                    ord[idx] = h;
                    idx++;
                end
            end
        end
        check("rr_count", idx, 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), ord[i], i % 2);
        h_req[0] = 1'b0;
        h_req[1] = 1'b0;
        cycle();

        // Unmapped write by host 1, then a normal read by host 0
        host_cmd(1, 1'b1, 16'hFFFC, 32'h1234_5678);
        sp_lat = 1; sp_next_status = RGGEN_SLAVE_ERROR;
        wait_done(1, 12, n);
        check("unmapped_write_done", cap_wr[1], 1'b1);
        check("unmapped_no_read_done", cap_rd[1], 1'b0);
        check("unmapped_status", cap_status[1], RGGEN_SLAVE_ERROR);
        h_req[1] = 1'b0;
        host_cmd(0, 1'b0, 16'h0020, '0);
        sp_next_status = RGGEN_OKAY; sp_next_rdata = 32'h5A5A_0020;
        wait_done(0, 12, n);
        check("after_error_status", cap_status[0], RGGEN_OKAY);
        check("after_error_data", cap_rdata[0], 32'h5A5A_0020);
        h_req[0] = 1'b0;

        // Reset while host 1 is being served
        host_cmd(1, 1'b0, 16'h0004, '0);
        sp_lat = 20;
        cycle(); cycle(); cycle();
        check("mid_busy_grant", grant, 2'b10);
        rst_n = 1'b0;
        d0 = done_cnt[1];
        cycle();
        check("mid_reset_grant", grant, 2'b00);
        check("mid_reset_bus_request", bus_if.request, 1'b0);
        check("mid_reset_no_done", done_cnt[1], d0);
        rst_n = 1'b1;
        sp_lat = 1; sp_next_rdata = 32'h0000_0404;
        wait_done(1, 12, n);
        check("rearb_latency", n, 3);
        check("rearb_data", cap_rdata[1], 32'h0000_0404);
        h_req[1] = 1'b0;

        // Back-to-back writes from a single host
        host_cmd(0, 1'b1, 16'h0040, 32'hDEAD_BEEF);
        sp_lat = 0;
        d0 = wr_cnt[0]; lows = 0; started = 1'b0;
        for (int c = 0; c < 30 && (wr_cnt[0] - d0) < 3; c++) begin
            cycle();
            if (obs_bus_req) started = 1'b1;
            else if (started) lows++;
        end
        check("b2b_write_dones", wr_cnt[0] - d0, 3);
        check("b2b_idle_gaps", lows, 2);
        h_req[0] = 1'b0;
        cycle();

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        // Splitter never answers; a late done must be dropped
        sp_auto = 1'b0;
        host_cmd(0, 1'b0, 16'h0030, '0);
        wait_done(0, 20, n);
        check("timeout_latency", n, 9);
        check("timeout_status", cap_status[0], RGGEN_SLAVE_ERROR);
        check("timeout_read_done", cap_rd[0], 1'b1);
        check("timeout_read_data", cap_rdata[0], 32'h0);
        h_req[0] = 1'b0;
        d0 = done_cnt[0];
        cycle();
        sp_done = 1'b1; sp_rdone = 1'b1; sp_rdata = 32'h7777_7777; sp_status = RGGEN_OKAY;
        cycle();
        sp_done = 1'b0; sp_rdone = 1'b0; sp_rdata = '0;
        check("late_done_dropped", done_cnt[0], d0);
        sp_auto = 1'b1;
`endif

        // Random traffic against the model
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        sp_rand = 1'b1; sp_lat = 1; sp_next_rdata = 32'h0BAD_F00D; sp_next_status = RGGEN_OKAY;
        for (int c = 0; c < 500; c++) begin
            for (int h = 0; h < N; h++) begin
                if (seen_done[h]) h_req[h] = 1'b0;
                if (!h_req[h] && $urandom_range(0, 2) == 0) begin
                    h_req[h]   = 1'b1;
                    h_addr[h]  = AW'($urandom);
                    h_dir[h]   = 1'($urandom_range(0, 1));
                    h_wdata[h] = DW'($urandom);
                    h_strb[h]  = SW'($urandom);
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "simulation time limit");
    end
endmodule
`default_nettype wire
